// File: rtl/state_machine.sv
// Clocked 1-bit full adder: start captures A/B/CIN, next cycle registers S/COUT, FSM IDLE->ADD->DONE.
// Latency: S/COUT update on the edge after the capture edge, then hold until the next result or reset.
// Backpressure: none; start is ignored while in ADD, and DONE with start held high recaptures back-to-back.
// Optional: define SM_STATE_OUT_EN to expose the 2-bit state register on port 'state'.
module state_machine (
    input  logic       CLK,
    input  logic       NRST,
    input  logic       start,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       CIN,
    output logic       S,
    output logic       COUT
`ifdef SM_STATE_OUT_EN
    ,
    output logic [1:0] state
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ADD     = 2'b01,
        DONE    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t state_q;
    logic   a_q;
    logic   b_q;
    logic   c_q;

    // Controller and datapath in one register block; both resets clear everything, NRST checked first.
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q <= IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
            S       <= 1'b0;
            COUT    <= 1'b0;
        end else if (rst) begin
            state_q <= IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
            S       <= 1'b0;
            COUT    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        c_q     <= CIN;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    // Only the captured operands feed the result; live inputs are ignored here.
                    S       <= a_q ^ b_q ^ c_q;
                    COUT    <= (a_q & b_q) | (a_q & c_q) | (b_q & c_q);
                    state_q <= DONE;
                end
                DONE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        c_q     <= CIN;
                        state_q <= ADD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    // Unreachable code 2'b11: recover to IDLE, results untouched.
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SM_STATE_OUT_EN
    assign state = state_q;
`endif

endmodule

// File: tb/tb_state_machine.sv
// Self-checking bench for state_machine: directed test-plan vectors plus randomized traffic.
// Reference: operands become an arithmetic sum at a capture, published one edge later.
// A capture cannot follow a capture on the very next edge (the publishing edge ignores start).
module tb_state_machine;

    logic CLK;
    logic NRST;
    logic start;
    logic rst;
    logic A;
    logic B;
    logic CIN;
    logic S;
    logic COUT;
`ifdef SM_STATE_OUT_EN
    logic [1:0] state;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    state_machine dut (
        .CLK   (CLK),
        .NRST  (NRST),
        .start (start),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .CIN   (CIN),
        .S     (S),
        .COUT  (COUT)
`ifdef SM_STATE_OUT_EN
        ,
        .state (state)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: result pending flag, captured arithmetic sum, published outputs.
    logic       m_s    = 1'b0;
    logic       m_cout = 1'b0;
    bit         m_pend = 1'b0;
    bit         m_done = 1'b0;
    int         m_sum  = 0;

    always @(posedge CLK) begin
        if (!NRST || rst) begin
            m_s    = 1'b0;
            m_cout = 1'b0;
            m_pend = 1'b0;
            m_done = 1'b0;
        end else if (m_pend) begin
            m_s    = m_sum[0];
            m_cout = m_sum[1];
            m_pend = 1'b0;
            m_done = 1'b1;
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_sum  = int'(A) + int'(B) + int'(CIN);
                m_pend = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at time %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_S", {1'b0, S}, {1'b0, m_s});
            check("model_COUT", {1'b0, COUT}, {1'b0, m_cout});
`ifdef SM_STATE_OUT_EN
            check("model_state", state, m_pend ? 2'b01 : (m_done ? 2'b10 : 2'b00));
`endif
        end
    end

    // One cycle: drive inputs after the falling edge, return just after the rising edge.
    task automatic step(input logic n, input logic r, input logic st,
                        input logic a, input logic b, input logic c);
        @(negedge CLK);
        NRST  = n;
        rst   = r;
        start = st;
        A     = a;
        B     = b;
        CIN   = c;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        NRST = 1'b1; rst = 1'b0; start = 1'b0; A = 1'b0; B = 1'b0; CIN = 1'b0;

        // Reset, then all inputs quiet
        step(0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        check("reset_out", {COUT, S}, 2'b00);

        // 1+1+1 held for three cycles
        step(1, 0, 1, 1, 1, 1);
        step(1, 0, 1, 1, 1, 1);
        check("add_111", {COUT, S}, 2'b11);
        step(1, 0, 1, 1, 1, 1);
        check("add_111_hold", {COUT, S}, 2'b11);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // A=1 only -> S=1, COUT=0
        step(1, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("add_100", {COUT, S}, 2'b01);
        step(1, 0, 0, 0, 0, 0);
        // A=1, B=1 -> S=0, COUT=1
        step(1, 0, 1, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        check("add_110", {COUT, S}, 2'b10);
        step(1, 0, 0, 0, 0, 0);

        // CIN only captured; A/B driven high during the compute cycle must not matter
        step(1, 0, 1, 0, 0, 1);
        step(1, 0, 1, 1, 1, 1);
        check("capture_isolation", {COUT, S}, 2'b01);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Soft reset with start high wins
        step(1, 0, 1, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        check("pre_rst", {COUT, S}, 2'b11);
        step(1, 1, 1, 1, 1, 1);
        check("rst_wins", {COUT, S}, 2'b00);
        step(1, 0, 0, 0, 0, 0);

        // Same with NRST
        step(1, 0, 1, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        check("pre_nrst", {COUT, S}, 2'b11);
        step(0, 0, 1, 1, 1, 1);
        check("nrst_wins", {COUT, S}, 2'b00);
        step(1, 0, 0, 0, 0, 0);

        // Reset mid-operation leaves no partial result
        step(1, 0, 1, 1, 1, 1);
        step(1, 1, 0, 0, 0, 0);
        check("rst_mid_op", {COUT, S}, 2'b00);
        step(1, 0, 0, 0, 0, 0);
        check("rst_mid_op_after", {COUT, S}, 2'b00);

        // Result holds in IDLE while data toggles
        step(1, 0, 1, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 1'($urandom), 1'($urandom), 1'($urandom));
            check("idle_hold", {COUT, S}, 2'b10);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) >= 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                 1'($urandom), 1'($urandom), 1'($urandom));
        end

        @(negedge CLK);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
